// File: rtl/arb_req_pkg.sv
// Shared state encoding, default sizes and helpers for the arbiter requester agent.
package arb_req_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_TIMEOUT_CYC = 64;

  function automatic int clog2(input int value);
    int result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/arb_req_fifo.sv
// Beat buffer of {data, last} that also counts complete packets and forces
// last on a non-last beat that would fill the buffer with no packet inside.
module arb_req_fifo
  import arb_req_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  localparam int AW    = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       pkt_cnt,
  output logic              trunc
);

  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ALMOST_CNT = FULL_CNT - 1'b1;

  logic [DATA_W:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            store_last;
  logic            pkt_inc;
  logic            pkt_dec;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign trunc      = push && !push_last && !pop && (count == ALMOST_CNT) && (pkt_cnt == '0);
  assign store_last = push_last | trunc;
  assign head_data  = mem[rd_ptr][DATA_W:1];
  assign head_last  = mem[rd_ptr][0];
  assign pkt_inc    = push & store_last;
  assign pkt_dec    = pop & head_last;

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_data, store_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule

// File: rtl/arb_req_agent.sv
// Requester agent: buffers packets, requests the arbiter and streams a packet while granted.
// Optional request-wait timeout flag is built when ARB_REQ_TIMEOUT_EN is defined.
module arb_req_agent
  import arb_req_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              req,
  input  logic              grant,
  output logic              bus_valid,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_last,
  output logic              busy,
  input  logic              err_clr,
  output logic              trunc_err,
  output logic              grant_lost_err,
  output logic              req_timeout
);

  localparam int AW = clog2(FIFO_DEPTH);

  state_t            state_q;
  state_t            state_d;
  logic              req_d;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_last;
  logic              trunc;
  logic              grant_lost_set;
  logic [DATA_W-1:0] head_data;
  logic [AW:0]       unused_fifo_count;
  logic [AW:0]       pkt_cnt;

  assign s_ready = !fifo_full;
  assign push    = s_valid & s_ready;

  arb_req_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (s_data),
    .push_last (s_last),
    .pop       (pop),
    .head_data (head_data),
    .head_last (head_last),
    .count     (unused_fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .pkt_cnt   (pkt_cnt),
    .trunc     (trunc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req     <= 1'b0;
    end else begin
      state_q <= state_d;
      req     <= req_d;
    end
  end

  // Bus beats appear only in XFER while granted, so the extra grant cycle after release is ignored.
  always_comb begin
    state_d        = state_q;
    req_d          = req;
    bus_valid      = 1'b0;
    pop            = 1'b0;
    grant_lost_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pkt_cnt != '0) begin
          state_d = ST_REQ;
          req_d   = 1'b1;
        end
      end
      ST_REQ: begin
        req_d = 1'b1;
        if (grant) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (grant) begin
          bus_valid = !fifo_empty;
          pop       = !fifo_empty;
          if (!fifo_empty && head_last) begin
            req_d   = 1'b0;
            state_d = ST_RELEASE;
          end
        end else begin
          grant_lost_set = 1'b1;
          state_d        = ST_REQ;
        end
      end
      ST_RELEASE: begin
        req_d = 1'b0;
        if (!grant) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign bus_data = head_data;
  assign bus_last = bus_valid & head_last;
  assign busy     = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trunc_err      <= 1'b0;
      grant_lost_err <= 1'b0;
    end else begin
      if (trunc)        trunc_err <= 1'b1;
      else if (err_clr) trunc_err <= 1'b0;
      if (grant_lost_set) grant_lost_err <= 1'b1;
      else if (err_clr)   grant_lost_err <= 1'b0;
    end
  end

`ifdef ARB_REQ_TIMEOUT_EN
  localparam int            TW      = clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] wait_cnt;
  logic          timeout_q;

  // The wait counter restarts on every REQ entry and saturates; the request is never withdrawn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q != ST_REQ)      wait_cnt <= '0;
      else if (wait_cnt != TO_LAST) wait_cnt <= wait_cnt + 1'b1;
      if ((state_q == ST_REQ) && (wait_cnt == TO_LAST)) timeout_q <= 1'b1;
      else if (err_clr)                                  timeout_q <= 1'b0;
    end
  end

  assign req_timeout = timeout_q;
`else
  assign req_timeout = 1'b0 & (TIMEOUT_CYC > 0);
`endif

endmodule

// File: tb/tb_arb_req_agent.sv
// Directed bench for arb_req_agent with a latency-2 registered arbiter model.
module tb_arb_req_agent;

  localparam int DATA_W      = 32;
  localparam int FIFO_DEPTH  = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int ARB_LAT     = 2;
`ifdef ARB_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              busy;
  logic              err_clr;
  logic              trunc_err;
  logic              grant_lost_err;
  logic              req_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_req_agent #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_data         (s_data),
    .s_last         (s_last),
    .req            (req),
    .grant          (grant),
    .bus_valid      (bus_valid),
    .bus_data       (bus_data),
    .bus_last       (bus_last),
    .busy           (busy),
    .err_clr        (err_clr),
    .trunc_err      (trunc_err),
    .grant_lost_err (grant_lost_err),
    .req_timeout    (req_timeout)
  );

  // Arbiter model: grant rises ARB_LAT cycles after req, falls the cycle after req falls.
  // grant_block forces grant low while keeping the latency count so it returns at once.
  logic grant_block;
  int   arb_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= 1'b0;
      arb_cnt <= 0;
    end else if (!req) begin
      grant   <= 1'b0;
      arb_cnt <= 0;
    end else if (grant_block) begin
      grant <= 1'b0;
    end else if (arb_cnt == ARB_LAT - 1) begin
      grant <= 1'b1;
    end else begin
      arb_cnt <= arb_cnt + 1;
    end
  end

  // Bus monitor: records beats with their cycle and the req-low gap before each req rise.
  logic [DATA_W-1:0] beat_data [256];
  logic              beat_last [256];
  int                beat_cyc  [256];
  int                beat_wr = 0;
  int                gap_list  [64];
  int                gap_wr = 0;
  int                rise_cnt = 0;
  int                low_run = 0;
  int                cyc = 0;
  logic              req_prev = 1'b0;
  logic              seen_fall = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      req_prev  <= 1'b0;
      seen_fall <= 1'b0;
      low_run   <= 0;
    end else begin
      req_prev <= req;
      low_run  <= req ? 0 : low_run + 1;
      if (req && !req_prev) begin
        rise_cnt <= rise_cnt + 1;
        if (seen_fall) begin
          gap_list[gap_wr] <= low_run;
          gap_wr           <= gap_wr + 1;
        end
      end
      if (!req && req_prev) seen_fall <= 1'b1;
      if (bus_valid) begin
        checks++;
        if (!grant) begin
          errors++;
          $display("[TB] FAIL bus_valid_without_grant: grant=%0b required 1 at cycle %0d", grant, cyc);
        end
        beat_data[beat_wr] <= bus_data;
        beat_last[beat_wr] <= bus_last;
        beat_cyc[beat_wr]  <= cyc;
        beat_wr            <= beat_wr + 1;
      end
    end
  end

  typedef struct {
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        exp_req;
    logic        exp_bus_valid;
    logic [31:0] exp_bus_data;
    logic        exp_bus_last;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mkVec(input logic sv, input logic [31:0] sd, input logic sl,
                                 input logic rq, input logic bv, input logic [31:0] bd,
                                 input logic bl, input logic bz);
    vec_t v;
    v.s_valid = sv; v.s_data = sd; v.s_last = sl;
    v.exp_req = rq; v.exp_bus_valid = bv; v.exp_bus_data = bd;
    v.exp_bus_last = bl; v.exp_busy = bz;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    s_valid = v.s_valid;
    s_data  = v.s_data;
    s_last  = v.s_last;
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    checkValue($sformatf("vec%0d req", i), req, v.exp_req);
    checkValue($sformatf("vec%0d bus_valid", i), bus_valid, v.exp_bus_valid);
    checkValue($sformatf("vec%0d bus_last", i), bus_last, v.exp_bus_last);
    checkValue($sformatf("vec%0d busy", i), busy, v.exp_busy);
    checkValue($sformatf("vec%0d s_ready", i), s_ready, 1'b1);
    if (v.exp_bus_valid) checkValue($sformatf("vec%0d bus_data", i), bus_data, v.exp_bus_data);
  endtask

  task automatic pushBeat(input logic [31:0] d, input logic l);
    int n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) checkValue("push_wait_s_ready", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic waitBeats(input string name, input int target);
    int n = 0;
    while (beat_wr < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, " beat_count"}, beat_wr, target);
  endtask

  task automatic waitIdle(input string name);
    int n = 0;
    while ((busy || req) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, " idle"}, busy, 1'b0);
  endtask

  task automatic waitBusValid(input string name);
    int n = 0;
    while (!bus_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkValue({name, " bus_valid_seen"}, bus_valid, 1'b1);
  endtask

  task automatic checkBeat(input string name, input int idx, input logic [31:0] d, input logic l);
    checkValue({name, " data"}, beat_data[idx], d);
    checkValue({name, " last"}, beat_last[idx], l);
  endtask

  task automatic checkGaps(input string name, input int from);
    for (int g = from; g < gap_wr; g++)
      checkValue($sformatf("%s gap%0d>=3 (gap=%0d)", name, g, gap_list[g]), gap_list[g] >= 3, 1'b1);
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int gbase;
    int rbase;
    int n;

    // Cycle-by-cycle trace of a 3-beat packet; row i holds the outputs of cycle i
    // and the inputs driven during cycle i.
    vecs[0]  = mkVec(1, 32'hA0, 0, 0, 0, 0,     0, 0);
    vecs[1]  = mkVec(1, 32'hA1, 0, 0, 0, 0,     0, 0);
    vecs[2]  = mkVec(1, 32'hA2, 1, 0, 0, 0,     0, 0);
    vecs[3]  = mkVec(0, 0,      0, 0, 0, 0,     0, 0);
    vecs[4]  = mkVec(0, 0,      0, 1, 0, 0,     0, 1);
    vecs[5]  = mkVec(0, 0,      0, 1, 0, 0,     0, 1);
    vecs[6]  = mkVec(0, 0,      0, 1, 0, 0,     0, 1);
    vecs[7]  = mkVec(0, 0,      0, 1, 1, 'hA0,  0, 1);
    vecs[8]  = mkVec(0, 0,      0, 1, 1, 'hA1,  0, 1);
    vecs[9]  = mkVec(0, 0,      0, 1, 1, 'hA2,  1, 1);
    vecs[10] = mkVec(0, 0,      0, 0, 0, 0,     0, 1);
    vecs[11] = mkVec(0, 0,      0, 0, 0, 0,     0, 1);
    vecs[12] = mkVec(0, 0,      0, 0, 0, 0,     0, 0);
    vecs[13] = mkVec(0, 0,      0, 0, 0, 0,     0, 0);

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    err_clr = 1'b0; grant_block = 1'b0;
    repeat (2) @(negedge clk);

    checkValue("reset req", req, 1'b0);
    checkValue("reset s_ready", s_ready, 1'b1);
    checkValue("reset busy", busy, 1'b0);
    checkValue("reset bus_valid", bus_valid, 1'b0);
    checkValue("reset bus_last", bus_last, 1'b0);
    checkValue("reset trunc_err", trunc_err, 1'b0);
    checkValue("reset grant_lost_err", grant_lost_err, 1'b0);
    checkValue("reset req_timeout", req_timeout, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkOutput(i, vecs[i]);
      applyStimulus(vecs[i]);
    end

    // Two packets buffered back to back: 2 beats then 1 beat.
    @(negedge clk);
    base = beat_wr; gbase = gap_wr; rbase = rise_cnt;
    pushBeat(32'hB0, 1'b0);
    pushBeat(32'hB1, 1'b1);
    pushBeat(32'hC0, 1'b1);
    waitBeats("two_pkts", base + 3);
    waitIdle("two_pkts");
    checkBeat("two_pkts b0", base,     32'hB0, 1'b0);
    checkBeat("two_pkts b1", base + 1, 32'hB1, 1'b1);
    checkBeat("two_pkts c0", base + 2, 32'hC0, 1'b1);
    checkValue("two_pkts contiguous", beat_cyc[base + 1] - beat_cyc[base], 1);
    checkValue("two_pkts req_rises", rise_cnt - rbase, 2);
    checkValue("two_pkts gaps_recorded", gap_wr - gbase, 2);
    checkGaps("two_pkts", gbase);

    // Ten beats where only the tenth carries last: the eighth fills the buffer and is cut.
    base = beat_wr; gbase = gap_wr;
    for (int i = 0; i < 8; i++) pushBeat(32'hD0 + i, 1'b0);
    checkValue("trunc s_ready_full", s_ready, 1'b0);
    checkValue("trunc flag_set", trunc_err, 1'b1);
    pushBeat(32'hD8, 1'b0);
    pushBeat(32'hD9, 1'b1);
    waitBeats("trunc", base + 10);
    waitIdle("trunc");
    for (int i = 0; i < 10; i++)
      checkBeat($sformatf("trunc beat%0d", i), base + i, 32'hD0 + i, (i == 7) || (i == 9));
    checkValue("trunc first_pkt_contiguous", beat_cyc[base + 7] - beat_cyc[base], 7);
    checkGaps("trunc", gbase);
    checkValue("trunc flag_sticky", trunc_err, 1'b1);
    pulseClear();
    checkValue("trunc flag_cleared", trunc_err, 1'b0);

    // Grant dropped for two cycles after the first beat of a 4-beat packet.
    base = beat_wr;
    for (int i = 0; i < 4; i++) pushBeat(32'hE0 + i, i == 3);
    waitBusValid("drop");
    checkValue("drop first_beat", bus_data, 32'hE0);
    grant_block = 1'b1;
    @(negedge clk);
    checkValue("drop c1 grant", grant, 1'b0);
    checkValue("drop c1 bus_valid", bus_valid, 1'b0);
    checkValue("drop c1 req", req, 1'b1);
    @(negedge clk);
    checkValue("drop c2 grant", grant, 1'b0);
    checkValue("drop c2 bus_valid", bus_valid, 1'b0);
    checkValue("drop c2 req", req, 1'b1);
    checkValue("drop grant_lost_err", grant_lost_err, 1'b1);
    grant_block = 1'b0;
    waitBeats("drop", base + 4);
    waitIdle("drop");
    for (int i = 0; i < 4; i++)
      checkBeat($sformatf("drop beat%0d", i), base + i, 32'hE0 + i, i == 3);
    checkValue("drop resume_delay", beat_cyc[base + 1] - beat_cyc[base], 4);
    checkValue("drop resume_contiguous", beat_cyc[base + 3] - beat_cyc[base + 1], 2);
    pulseClear();
    checkValue("drop flag_cleared", grant_lost_err, 1'b0);

    // Grant withheld: the timeout flag (when built) rises 16 cycles after REQ entry.
    base = beat_wr;
    grant_block = 1'b1;
    pushBeat(32'hF0, 1'b1);
    n = 0;
    while (!req && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkValue("timeout req_entry", req, 1'b1);
    checkValue("timeout at_entry", req_timeout, 1'b0);
    repeat (15) @(negedge clk);
    checkValue("timeout at_entry+15", req_timeout, 1'b0);
    @(negedge clk);
    checkValue("timeout at_entry+16", req_timeout, TO_EN);
    checkValue("timeout req_held", req, 1'b1);
    grant_block = 1'b0;
    waitBeats("timeout", base + 1);
    waitIdle("timeout");
    checkBeat("timeout beat", base, 32'hF0, 1'b1);
    pulseClear();
    checkValue("timeout flag_cleared", req_timeout, 1'b0);

    // Asynchronous reset in the middle of a 4-beat transfer.
    base = beat_wr;
    for (int i = 0; i < 4; i++) pushBeat(32'h70 + i, i == 3);
    waitBusValid("rst_mid");
    #2 rst_n = 1'b0;
    #1;
    checkValue("rst_mid req", req, 1'b0);
    checkValue("rst_mid bus_valid", bus_valid, 1'b0);
    checkValue("rst_mid bus_last", bus_last, 1'b0);
    checkValue("rst_mid busy", busy, 1'b0);
    checkValue("rst_mid s_ready", s_ready, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checkValue("rst_mid no_req_after", req, 1'b0);
    checkValue("rst_mid idle_after", busy, 1'b0);
    checkValue("rst_mid fifo_empty", s_ready, 1'b1);
    checkValue("rst_mid beats_discarded", beat_wr, base + 1);
    pushBeat(32'h99, 1'b1);
    waitBeats("rst_mid next", base + 2);
    waitIdle("rst_mid next");
    checkBeat("rst_mid next_beat", base + 1, 32'h99, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_req_agent.md
# arb_req_agent

Requester-side agent for the single-cycle round-robin arbiter. It buffers an input packet stream, raises `req` once a complete packet is buffered, and waits for `grant`. While granted it streams the packet onto the shared bus one beat per cycle, then releases `req` and waits for `grant` to fall before it may request again. One instance sits on each arbiter request line; its `req` feeds arbiter `req[i]` and arbiter `grant[i]` returns to it.

## Interface
- `DATA_W`, 32: bus and stream data width.
- `FIFO_DEPTH`, 8: beat buffer depth; power of 2, ≥2. Also the maximum packet length in beats.
- `TIMEOUT_CYC`, 64: request-wait limit in cycles, used only under the configuration macro.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_valid` in 1: input beat valid.
- `s_ready` out 1: input beat accepted; equals FIFO not full.
- `s_data` in DATA_W: input beat data.
- `s_last` in 1: last beat of the packet.
- `req` out 1: registered request to the arbiter.
- `grant` in 1: registered grant from the arbiter.
- `bus_valid` out 1: beat driven on the shared bus this cycle.
- `bus_data` out DATA_W: beat data.
- `bus_last` out 1: last beat of the packet.
- `busy` out 1: state is not IDLE.
- `err_clr` in 1: synchronous clear of all sticky error flags.
- `trunc_err` out 1: sticky; a packet was truncated.
- `grant_lost_err` out 1: sticky; `grant` fell while `req` was high during a transfer.
- `req_timeout` out 1: sticky; the request wait exceeded the limit.

## Operation
- FIFO entry is {data, last}. Push when `s_valid & s_ready`.
- `pkt_cnt` tracks complete packets in the FIFO:
  - +1 on push with last=1.
  - −1 on pop with last=1.
  - Both in the same cycle: unchanged.
- Truncation: a push that fills the FIFO with a non-last beat while `pkt_cnt==0` is stored with last forced to 1, and `trunc_err` is set. The remaining input beats of that packet form a new packet.
- FSM states are IDLE, REQ, XFER and RELEASE.
  - IDLE: when `pkt_cnt>0`, set `req`←1 and go to REQ.
  - REQ: hold `req`=1. When `grant`=1 is sampled, go to XFER.
  - XFER, with `grant`=1:
    - `bus_valid`=1; `bus_data` and `bus_last` come from the FIFO head; pop every cycle. There is no bus backpressure.
    - On a beat with last=1: `req`←0, go to RELEASE.
  - XFER, with `grant`=0:
    - `bus_valid`=0 and no pop.
    - Set `grant_lost_err`, return to REQ with `req` held at 1, and resume the remaining beats when grant is regained.
  - RELEASE: `req`=0. When `grant`=0 is sampled, go to IDLE.
- `bus_valid`, `bus_data` and `bus_last` are combinational from state, `grant` and the FIFO head. `bus_data` is don't-care when `bus_valid`=0.
- The agent never drives `bus_valid` outside XFER, even though `grant` stays high for one cycle after `req` falls.
- `err_clr` clears all sticky flags. If a set condition occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE.
  - `req`, `bus_valid`, `bus_last`, `busy`, all error flags: 0.
  - `s_ready`=1.
  - FIFO pointers, count and `pkt_cnt`: 0.
- Reset mid-operation: FIFO contents are discarded and `req` falls immediately (asynchronous).
- Sequence for one packet:
  - `s_last` pushed at cycle t.
  - `req`=1 from t+2: `pkt_cnt` updates at t+1, then IDLE raises `req`.
  - With arbiter latency L cycles, `grant` rises at t+2+L.
  - First beat at t+3+L.
  - N beats are contiguous.
- Release, with the last beat in cycle k:
  - `req`=0 from k+1.
  - `grant` is still 1 in k+1 and falls in k+2.
  - IDLE at k+3.
  - Earliest new `req` at k+4.
- Minimum `req`-low gap is 3 cycles. This guarantees the arbiter's counter sees noGrant and rotates.
- A single-beat packet gives `bus_valid` and `bus_last` for exactly one cycle.
- FIFO pointers wrap modulo FIFO_DEPTH. A full-width count distinguishes full from empty. Simultaneous push and pop at full is not possible because `s_ready`=0.

## Configuration
- `ARB_REQ_TIMEOUT_EN` defined:
  - A wait counter runs in REQ, reset on entry.
  - When it reaches TIMEOUT_CYC−1, `req_timeout` is set.
  - `req` stays high and the request is not aborted. The counter saturates.
- `ARB_REQ_TIMEOUT_EN` undefined:
  - No counter is built.
  - `req_timeout` is tied to 0.
  - `TIMEOUT_CYC` is ignored.

## Structure
- Package `arb_req_pkg`:
  - State encoding typedef for IDLE/REQ/XFER/RELEASE.
  - Default constants for `FIFO_DEPTH` and `TIMEOUT_CYC`.
  - `clog2` function.
- Sub-module `arb_req_fifo`: synchronous FIFO of {data, last} with count, full and empty outputs, and the `pkt_cnt` and truncation logic.
- The FSM, error flags and timeout counter stay in the top module.

## Test plan
- Push a 3-beat packet (0xA0, 0xA1, 0xA2 with last), arbiter model grants 2 cycles after `req`:
  - 3 contiguous `bus_valid` beats; `bus_last` on 0xA2.
  - `req` falls the cycle after 0xA2.
  - Next `req` no earlier than 3 cycles after the fall.
- Two packets buffered back-to-back, 2 and 1 beats:
  - Two separate req/grant cycles.
  - Each shows a `req`-low gap of at least 3 cycles.
- With FIFO_DEPTH=8, push 10 beats and no last:
  - Beat 8 stored as last; `trunc_err`=1.
  - Packet of 8 beats on the bus, then a 2-beat packet.
  - `err_clr` clears the flag.
- Drop `grant` for 2 cycles mid-packet of 4 beats:
  - `bus_valid`=0 during the drop; `grant_lost_err`=1.
  - Remaining beats resume in order after grant returns.
- With `ARB_REQ_TIMEOUT_EN` and TIMEOUT_CYC=16, hold `grant` at 0:
  - `req_timeout` rises 16 cycles after REQ entry; `req` stays 1.
  - Late grant still completes the packet.
- Assert `rst_n`=0 during XFER of a 4-beat packet:
  - `req` and `bus_valid` fall at once; FIFO is empty after reset; `s_ready`=1.
